// File: rtl/app_ini_feeder_pkg.sv
// Shared types and defaults for the APP initial-message feeder.
// Current decoder configuration: 8 channels, 16-beat sub-blocks, 128-beat tail.
package app_ini_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_WAIT,
        S_FIN
    } feeder_state_e;

    localparam int NUM_CH_DEF   = 8;
    localparam int ADDR_W_DEF   = 2;
    localparam int SUBX_W_DEF   = 2;
    localparam int NUM_SUBX     = 2 ** SUBX_W_DEF;
    localparam int LEN_W_DEF    = 8;
    localparam int BLK_W_DEF    = 3;
    localparam int RD_LAT_DEF   = 2;
    localparam int LEN_SUB_DEF  = 16;
    localparam int LEN_LAST_DEF = 128;

endpackage

// File: rtl/app_ini_feeder_if.sv
// Decoder-side bundle: buffer port strobes/addresses plus decoder status.
// The feeder is the master; the decoder (or bench) is the slave.
interface app_ini_feeder_if #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 2,
    parameter int SUBX_W = 2
);
    logic                     dec_ready;
    logic                     blk_done;
    logic [NUM_CH*ADDR_W-1:0] buf_addr;
    logic                     buf_valid;
    logic                     buf_start;
    logic                     buf_last;
    logic [SUBX_W-1:0]        sub_x;

    modport master (
        input  dec_ready, blk_done,
        output buf_addr, buf_valid, buf_start,
        output buf_last, sub_x
    );

    modport slave (
        output dec_ready, blk_done,
        input  buf_addr, buf_valid, buf_start,
        input  buf_last, sub_x
    );
endinterface

// File: rtl/feeder_delay_line.sv
// Fixed-depth register pipe with synchronous clear.
// Aligns issue-side strobes with the buffer memory read latency.
module feeder_delay_line #(
    parameter int W     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                pipe_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/app_ini_feeder.sv
// Streams initial APP messages from NUM_CH buffer memories into the
// LDPC decoder, one code block per decoder-ready window.
module app_ini_feeder
    import app_ini_feeder_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SUBX_W = SUBX_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int BLK_W  = BLK_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_clr,
    input  logic                     cfg_go,
    input  logic [LEN_W-1:0]         cfg_len_sub,
    input  logic [LEN_W-1:0]         cfg_len_last,
    input  logic [BLK_W-1:0]         cfg_num_blk,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_ch_base,
    app_ini_feeder_if.master         dec,
    output logic                     busy,
    output logic                     done
);
    localparam int NSUB = 2 ** SUBX_W;
    localparam int DW   = 3 + SUBX_W;
    localparam int AW   = NUM_CH * ADDR_W;

    feeder_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_sub_q, len_sub_d;
    logic [LEN_W-1:0] len_last_q, len_last_d;
    logic [BLK_W-1:0] num_q, num_d;
    logic [AW-1:0]    base_q, base_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [SUBX_W-1:0] subx_q, subx_d;
    logic [BLK_W-1:0] fed_q, fed_d;
    logic [BLK_W-1:0] dcnt_q, dcnt_d;
    logic [2:0]       drain_q, drain_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] cur_len;
    logic             beat_wrap, last_sub;
    logic             iss_v, iss_s, iss_l;
    logic [SUBX_W-1:0] off;
    logic [DW-1:0]    dl_q;

    assign busy = (state_q == S_ARM) || (state_q == S_RUN) ||
                  (state_q == S_DRAIN) || (state_q == S_WAIT);
    assign done = (state_q == S_FIN);

    assign last_sub  = (subx_q == SUBX_W'(NSUB - 1));
    assign cur_len   = last_sub ? len_last_q : len_sub_q;
    assign beat_wrap = (beat_q == cur_len - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        len_sub_d  = len_sub_q;
        len_last_d = len_last_q;
        num_d      = num_q;
        base_d     = base_q;
        beat_d     = beat_q;
        subx_d     = subx_q;
        fed_d      = fed_q;
        dcnt_d     = dcnt_q;
        drain_d    = drain_q;
        iss_v      = 1'b0;
        iss_s      = 1'b0;
        iss_l      = 1'b0;
        if (dec.blk_done && busy && dcnt_q != '1)
            dcnt_d = dcnt_q + BLK_W'(1);
        unique case (state_q)
            S_IDLE: if (cfg_go) begin
                // zero-length sub-blocks are issued as one beat
                len_sub_d  = (cfg_len_sub == '0) ?
                             LEN_W'(1) : cfg_len_sub;
                len_last_d = (cfg_len_last == '0) ?
                             LEN_W'(1) : cfg_len_last;
                num_d      = cfg_num_blk;
                base_d     = cfg_ch_base;
                fed_d      = '0;
                dcnt_d     = '0;
                state_d    = (cfg_num_blk == '0) ? S_FIN : S_ARM;
            end
            S_ARM: begin
                beat_d = '0;
                subx_d = '0;
                if (dec.dec_ready)
                    state_d = S_RUN;
            end
            S_RUN: begin
                iss_v = 1'b1;
                iss_s = (beat_q == '0) && (subx_q == '0);
                iss_l = beat_wrap && last_sub;
                if (beat_wrap) begin
                    beat_d = '0;
                    subx_d = subx_q + SUBX_W'(1);
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
                if (iss_l) begin
                    fed_d   = fed_q + BLK_W'(1);
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 3'(1);
                if (drain_q == 3'(RD_LAT - 1))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dcnt_q >= num_q)
                    state_d = S_FIN;
                else if (fed_q < num_q && dec.dec_ready)
                    state_d = S_RUN;
            end
            S_FIN: if (cfg_go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (soft_clr) begin
            state_d = S_IDLE;
            beat_d  = '0;
            subx_d  = '0;
            fed_d   = '0;
            dcnt_d  = '0;
            drain_d = '0;
            iss_v   = 1'b0;
            iss_s   = 1'b0;
            iss_l   = 1'b0;
        end
    end

    // address leads the beat so memory dout lines up with the strobes
    always_comb begin
        addr_d = '0;
        off    = (state_d == S_RUN) ? subx_d : '0;
        if (state_d == S_ARM || state_d == S_RUN ||
            state_d == S_DRAIN || state_d == S_WAIT) begin
            for (int c = 0; c < NUM_CH; c++)
                addr_d[c*ADDR_W +: ADDR_W] =
                    base_d[c*ADDR_W +: ADDR_W] + ADDR_W'(off);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_sub_q  <= '0;
            len_last_q <= '0;
            num_q      <= '0;
            base_q     <= '0;
            beat_q     <= '0;
            subx_q     <= '0;
            fed_q      <= '0;
            dcnt_q     <= '0;
            drain_q    <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_sub_q  <= len_sub_d;
            len_last_q <= len_last_d;
            num_q      <= num_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            subx_q     <= subx_d;
            fed_q      <= fed_d;
            dcnt_q     <= dcnt_d;
            drain_q    <= drain_d;
            addr_q     <= addr_d;
        end
    end

    feeder_delay_line #(
        .W     (DW),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (soft_clr),
        .d_i   ({iss_v, iss_s, iss_l, subx_q}),
        .q_o   (dl_q)
    );

    assign dec.buf_addr  = addr_q;
    assign dec.buf_valid = dl_q[DW-1];
    assign dec.buf_start = dl_q[DW-2];
    assign dec.buf_last  = dl_q[DW-3];
    assign dec.sub_x     = dl_q[SUBX_W-1:0];
endmodule

// File: tb/tb_app_ini_feeder.sv
// Directed bench for app_ini_feeder: RD_LAT=2 main DUT plus an
// RD_LAT=1 instance for the short-block case.
module tb_app_ini_feeder;
    import app_ini_feeder_pkg::*;

    localparam int NC = 8;
    localparam int AW = 2;
    localparam int SW = 2;
    localparam int LW = 8;
    localparam int BW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_clr = 1'b0;
    logic cfg_go = 1'b0;
    logic [LW-1:0] cfg_len_sub = '0;
    logic [LW-1:0] cfg_len_last = '0;
    logic [BW-1:0] cfg_num_blk = '0;
    logic [NC*AW-1:0] cfg_ch_base = '0;
    logic busy0, done0, busy1, done1;

    app_ini_feeder_if #(.NUM_CH(NC), .ADDR_W(AW), .SUBX_W(SW)) b0();
    app_ini_feeder_if #(.NUM_CH(NC), .ADDR_W(AW), .SUBX_W(SW)) b1();

    assign b1.dec_ready = b0.dec_ready;
    assign b1.blk_done  = b0.blk_done;

    app_ini_feeder #(
        .NUM_CH(NC), .ADDR_W(AW), .SUBX_W(SW),
        .LEN_W(LW), .BLK_W(BW), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .cfg_go(cfg_go), .cfg_len_sub(cfg_len_sub),
        .cfg_len_last(cfg_len_last), .cfg_num_blk(cfg_num_blk),
        .cfg_ch_base(cfg_ch_base), .dec(b0),
        .busy(busy0), .done(done0)
    );

    app_ini_feeder #(
        .NUM_CH(NC), .ADDR_W(AW), .SUBX_W(SW),
        .LEN_W(LW), .BLK_W(BW), .RD_LAT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .cfg_go(cfg_go), .cfg_len_sub(cfg_len_sub),
        .cfg_len_last(cfg_len_last), .cfg_num_blk(cfg_num_blk),
        .cfg_ch_base(cfg_ch_base), .dec(b1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*AW-1:0] exp_addr(
        input logic [NC*AW-1:0] base, input int s);
        logic [NC*AW-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++)
            r[c*AW +: AW] = base[c*AW +: AW] + AW'(s);
        return r;
    endfunction

    function automatic int sub_of(input int i, input int ls);
        return (i < 3 * ls) ? i / ls : 3;
    endfunction

    task automatic start(input int nb, input int ls, input int ll);
        @(negedge clk) soft_clr = 1'b1;
        @(negedge clk) soft_clr = 1'b0;
        cfg_num_blk  = BW'(nb);
        cfg_len_sub  = LW'(ls);
        cfg_len_last = LW'(ll);
        cfg_go = 1'b1;
        @(negedge clk) cfg_go = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input int lim,
                              output int waited);
        waited = 0;
        while (!(which ? b1.buf_valid : b0.buf_valid) && waited < lim) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, nv, ns, nl;
        logic [NC*AW-1:0] base;
        b0.dec_ready = 1'b1;
        b0.blk_done  = 1'b0;
        base = '0;
        base[5*AW +: AW] = 2'd3;
        cfg_ch_base = base;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", b0.buf_valid, 0);
        chk("rst_addr", b0.buf_addr, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // full default block, channel 5 based at 3
        start(1, LEN_SUB_DEF, LEN_LAST_DEF);
        chk("arm_busy", busy0, 1);
        chk("arm_addr", b0.buf_addr, exp_addr(base, 0));
        @(negedge clk);
        @(negedge clk);
        chk("lat_early", b0.buf_valid, 0);
        @(negedge clk);
        for (int i = 0; i < 176; i++) begin
            chk("b1_valid", b0.buf_valid, 1);
            chk("b1_start", b0.buf_start, 64'(i == 0));
            chk("b1_last", b0.buf_last, 64'(i == 175));
            chk("b1_subx", b0.sub_x, 64'(sub_of(i, 16)));
            chk("b1_addr", b0.buf_addr, (i + 2 <= 175) ?
                exp_addr(base, sub_of(i + 2, 16)) : exp_addr(base, 0));
            @(negedge clk);
        end
        chk("b1_after", b0.buf_valid, 0);
        chk("b1_wait_busy", busy0, 1);
        chk("b1_wait_done", done0, 0);
        b0.blk_done = 1'b1;
        @(negedge clk) b0.blk_done = 1'b0;
        @(negedge clk);
        chk("b1_fin_done", done0, 1);
        chk("b1_fin_busy", busy0, 0);

        // three blocks of 9 beats, ready dropped mid-run then held low
        start(3, 2, 3);
        wait_valid(0, 10, w);
        chk("m_first", b0.buf_valid, 1);
        for (int i = 0; i < 9; i++) begin
            chk("m_valid", b0.buf_valid, 1);
            chk("m_start", b0.buf_start, 64'(i == 0));
            chk("m_last", b0.buf_last, 64'(i == 8));
            if (i == 3) b0.dec_ready = 1'b0;
            @(negedge clk);
        end
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            nv += int'(b0.buf_valid);
            b0.blk_done = (k == 5);
            @(negedge clk);
        end
        chk("gap_valid", nv, 0);
        chk("gap_busy", busy0, 1);
        b0.dec_ready = 1'b1;
        wait_valid(0, 10, w);
        chk("b2_first", b0.buf_valid, 1);
        nv = 0; ns = 0; nl = 0;
        for (int k = 0; k < 40; k++) begin
            nv += int'(b0.buf_valid);
            ns += int'(b0.buf_start);
            nl += int'(b0.buf_last);
            @(negedge clk);
        end
        chk("b23_valid", nv, 18);
        chk("b23_start", ns, 2);
        chk("b23_last", nl, 2);
        chk("b23_busy", busy0, 1);
        chk("b23_done", done0, 0);
        b0.blk_done = 1'b1;
        @(negedge clk);
        @(negedge clk) b0.blk_done = 1'b0;
        @(negedge clk);
        chk("m_fin_done", done0, 1);
        chk("m_fin_busy", busy0, 0);

        // abort at beat 50, then restart
        start(1, LEN_SUB_DEF, LEN_LAST_DEF);
        wait_valid(0, 10, w);
        repeat (50) @(negedge clk);
        chk("c_v50", b0.buf_valid, 1);
        chk("c_sub50", b0.sub_x, 3);
        soft_clr = 1'b1;
        @(negedge clk) soft_clr = 1'b0;
        chk("c_valid", b0.buf_valid, 0);
        chk("c_start", b0.buf_start, 0);
        chk("c_last", b0.buf_last, 0);
        chk("c_subx", b0.sub_x, 0);
        chk("c_busy", busy0, 0);
        chk("c_done", done0, 0);
        chk("c_addr", b0.buf_addr, 0);
        cfg_go = 1'b1;
        @(negedge clk) cfg_go = 1'b0;
        wait_valid(0, 10, w);
        chk("r_valid", b0.buf_valid, 1);
        chk("r_start", b0.buf_start, 1);
        chk("r_subx", b0.sub_x, 0);

        // zero sub length on the RD_LAT=1 instance: 4-beat block
        start(1, 0, 1);
        wait_valid(1, 10, w);
        chk("s_lat", w, 2);
        for (int i = 0; i < 4; i++) begin
            chk("s_valid", b1.buf_valid, 1);
            chk("s_start", b1.buf_start, 64'(i == 0));
            chk("s_last", b1.buf_last, 64'(i == 3));
            chk("s_subx", b1.sub_x, 64'(i));
            @(negedge clk);
        end
        chk("s_after", b1.buf_valid, 0);

        // zero blocks: done right after cfg_go, no beats
        start(0, LEN_SUB_DEF, LEN_LAST_DEF);
        chk("z_done", done0, 1);
        chk("z_busy", busy0, 0);
        chk("z_done1", done1, 1);
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            nv += int'(b0.buf_valid) + int'(b1.buf_valid);
            @(negedge clk);
        end
        chk("z_valid", nv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/app_ini_feeder.md
Name: app_ini_feeder

Overview:
Synthesizable sequencer that streams initial APP (channel LLR) messages from NUM_CH input buffer memories into the LDPC decoder's buffer port. It generates per-channel buffer read addresses, the sub-block index, and the valid/start/last strobes, aligned to the memory read latency. It feeds a programmable number of code blocks, each only after the decoder signals ready, and replaces the hand-built stimulus sequencing used around LDPC_Dec.

Parameters:
NUM_CH, 8, number of input buffer memories (channels)
ADDR_W, 2, buffer address width per channel
SUBX_W, 2, sub-block index width; NUM_SUBX = 2**SUBX_W sub-blocks per code block
LEN_W, 8, beat-count width per sub-block
BLK_W, 3, code-block count width
RD_LAT, 2, buffer memory read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
soft_clr  in  1  synchronous abort, returns block to IDLE
cfg_go  in  1  one-cycle pulse that starts a feeding session; cfg_* sampled on this cycle
cfg_len_sub  in  LEN_W  beats per sub-block for sub_x < NUM_SUBX-1 (value 16 in the current config)
cfg_len_last  in  LEN_W  beats for the final sub-block (value 128 in the current config)
cfg_num_blk  in  BLK_W  number of code blocks in the session
cfg_ch_base  in  NUM_CH*ADDR_W  per-channel starting buffer address
dec_ready  in  1  decoder buffer_ready
blk_done  in  1  decoder decode_valid pulse, one per finished block
buf_addr  out  NUM_CH*ADDR_W  per-channel memory read addresses
buf_valid  out  1  data beat valid at the decoder, aligned to memory dout
buf_start  out  1  first beat of a code block
buf_last  out  1  final beat of a code block
sub_x  out  SUBX_W  sub-block index of the current beat
busy  out  1  session active
done  out  1  session complete (level until the next cfg_go or soft_clr)

Behaviour:
- Reset / soft_clr: state IDLE; all outputs 0; buf_addr = 0; all counters 0. soft_clr mid-block aborts immediately and drops pending pipeline strobes.
- A cfg_len value of 0 is treated as 1. cfg_num_blk = 0 sets done on the cycle after cfg_go, with no beats issued.
- FSM states:
  - IDLE: cfg_go moves to ARM; cfg_* are latched on the cfg_go cycle.
  - ARM: dec_ready = 1 moves to RUN; the issue counters are zeroed.
  - RUN: one issue beat per cycle. dec_ready is ignored while in RUN (a block is never stalled).
  - DRAIN: lasts RD_LAT cycles, then moves to WAIT.
  - WAIT: the blk_done count reaching cfg_num_blk moves to FIN. Otherwise, if fed < cfg_num_blk and dec_ready = 1, moves to RUN for the next block.
  - FIN: done = 1; moves to IDLE on cfg_go or soft_clr.
- Issue domain (undelayed):
  - beat counter: 0..len-1, where len = cfg_len_last when sub_x_i = NUM_SUBX-1, else cfg_len_sub.
  - sub_x_i increments when the beat counter wraps. When the last beat of the last sub-block issues, RUN moves to DRAIN and the fed counter increments.
- Addresses: buf_addr[c] = cfg_ch_base[c] + sub_x_i, modulo 2**ADDR_W, registered. The address changes RD_LAT cycles before the first beat of each sub-block reaches the output. The address is held at base during ARM, DRAIN and WAIT.
- Output domain: valid, first-beat flag, last-beat flag and sub_x_i are delayed by an RD_LAT-stage shift register.
  - buf_valid, buf_start and buf_last are the delayed values.
  - buf_start: single-cycle pulse on the first delayed beat of each block.
  - buf_last: single-cycle pulse on the last beat. When total length is 1, start and last are asserted together.
- blk_done counter saturates at 2**BLK_W-1. blk_done arriving during RUN is counted.
- busy = 1 in ARM, RUN, DRAIN and WAIT.
- Latency: ARM→RUN transition to first buf_valid = RD_LAT+1 cycles. Beats per block = (NUM_SUBX-1)*cfg_len_sub + cfg_len_last.

Decomposition:
- Shared package: FSM state encodings, the NUM_SUBX constant, and the current-config defaults (len_sub 16, len_last 128, 8 channels).
- One sub-module, feeder_delay_line: a parametrised RD_LAT-deep register pipe with synchronous clear, used for the valid/start/last/sub_x alignment.

Test Plan:
- Default parameters, cfg_len_sub=16, cfg_len_last=128, cfg_num_blk=1, dec_ready=1, then cfg_go → 176 buf_valid cycles.
  - buf_start on the first of these cycles, buf_last on the 176th.
  - sub_x steps 0,1,2,3 at beats 16, 32 and 48.
  - buf_addr = base+sub_x, RD_LAT cycles early.
- cfg_ch_base channel 5 = 3 → that channel's address sequence is 3,0,1,2 (wrap); other channels (base 0) sequence 0,1,2,3.
- cfg_num_blk=3, dec_ready held low for 20 cycles after block 1 → no block-2 beats until dec_ready rises; blk_done ×3 → done=1, busy=0.
- dec_ready dropped mid-RUN → beats continue uninterrupted until buf_last.
- soft_clr at beat 50 → next cycle all strobes 0, state IDLE; a subsequent cfg_go restarts at sub_x=0.
- cfg_len_sub=0, cfg_len_last=1, RD_LAT=1 → 4-beat block with start and last correctly placed; separately, cfg_num_blk=0 → done on the cycle after cfg_go, no buf_valid.
